// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: stage ctrl codes, FSM states, ctrl bundle.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned CTRL_CODE_W = 2;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned FLUSH_W     = 3;

  typedef enum logic [CTRL_CODE_W-1:0] {
    CTRL_DEFAULT = 2'd0,
    CTRL_BUBBLE  = 2'd1,
    CTRL_STALLED = 2'd2
  } ctrl_e;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'd0,
    PCTRL_FLUSH    = 2'd1,
    PCTRL_MEM_WAIT = 2'd2
  } pctrl_state_e;

  typedef struct packed {
    ctrl_e if_id;
    ctrl_e id_ex;
    ctrl_e ex_mem;
    ctrl_e mem_wb;
    logic  pc_wen;
  } ctrl_bus_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: EX load whose rd feeds a source register read in ID.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_rs1_read,
  input  logic                  i_id_rs2_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  input  logic                  i_ex_wreg,
  input  logic                  i_ex_is_load,
  output logic                  o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_id_rs1_read && (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit  = i_id_rs2_read && (i_id_rs2_addr == i_ex_rd_addr);
  // x0 never carries a real dependency
  assign o_load_use = i_ex_is_load && i_ex_wreg && (i_ex_rd_addr != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: per-stage ctrl codes and PC write enable for load-use, redirect and memory wait.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W       = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_read,
  input  logic                  id_rs2_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_wreg,
  input  logic                  ex_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [CTRL_W-1:0]     ctrl_if_id,
  output logic [CTRL_W-1:0]     ctrl_id_ex,
  output logic [CTRL_W-1:0]     ctrl_ex_mem,
  output logic [CTRL_W-1:0]     ctrl_mem_wb,
  output logic                  pc_wen,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  pctrl_state_e         r_state, w_state_nxt;
  logic [FLUSH_W-1:0]   r_flush_left, w_flush_nxt;
  logic                 r_branch_pend, w_pend_nxt;
  logic                 w_load_use;
  logic                 w_mem_wait;
  logic                 w_redirect;
  ctrl_bus_t            w_ctrl;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .i_id_rs1_addr (id_rs1_addr),
    .i_id_rs2_addr (id_rs2_addr),
    .i_id_rs1_read (id_rs1_read),
    .i_id_rs2_read (id_rs2_read),
    .i_ex_rd_addr  (ex_rd_addr),
    .i_ex_wreg     (ex_wreg),
    .i_ex_is_load  (ex_is_load),
    .o_load_use    (w_load_use)
  );

  assign w_mem_wait = mem_req_valid && !mem_req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= PCTRL_RUN;
      r_flush_left  <= '0;
      r_branch_pend <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_left  <= w_flush_nxt;
      r_branch_pend <= w_pend_nxt;
    end
  end

  // Next state and ctrl codes; priority is mem wait, redirect, flush, wait exit, load-use
  always_comb begin
    w_ctrl      = '{if_id: CTRL_DEFAULT, id_ex: CTRL_DEFAULT, ex_mem: CTRL_DEFAULT,
                    mem_wb: CTRL_DEFAULT, pc_wen: 1'b1};
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_left;
    w_pend_nxt  = r_branch_pend;
    w_redirect  = 1'b0;

    if (w_mem_wait) begin
      w_ctrl      = '{if_id: CTRL_STALLED, id_ex: CTRL_STALLED, ex_mem: CTRL_STALLED,
                      mem_wb: CTRL_BUBBLE, pc_wen: 1'b0};
      w_state_nxt = PCTRL_MEM_WAIT;
      if (ex_branch_taken) begin
        w_pend_nxt = 1'b1;
      end
    end else if (ex_branch_taken || ((r_state == PCTRL_MEM_WAIT) && r_branch_pend)) begin
      w_redirect   = 1'b1;
      w_ctrl.if_id = CTRL_BUBBLE;
      w_ctrl.id_ex = CTRL_BUBBLE;
      w_flush_nxt  = FLUSH_W'(FLUSH_CYCLES);
      w_pend_nxt   = 1'b0;
      w_state_nxt  = (FLUSH_CYCLES != 0) ? PCTRL_FLUSH : PCTRL_RUN;
    end else if (r_state == PCTRL_FLUSH) begin
      w_ctrl.if_id = CTRL_BUBBLE;
      w_flush_nxt  = r_flush_left - FLUSH_W'(1);
      if (r_flush_left <= FLUSH_W'(1)) begin
        w_state_nxt = PCTRL_RUN;
      end
    end else if (r_state == PCTRL_MEM_WAIT) begin
      // Exit without a pending branch: everything resumes this cycle
      w_state_nxt = PCTRL_RUN;
      w_flush_nxt = '0;
      w_pend_nxt  = 1'b0;
    end else if (w_load_use) begin
      w_ctrl.if_id  = CTRL_STALLED;
      w_ctrl.id_ex  = CTRL_BUBBLE;
      w_ctrl.pc_wen = 1'b0;
    end

    if (!rst) begin
      w_ctrl = '{if_id: CTRL_BUBBLE, id_ex: CTRL_BUBBLE, ex_mem: CTRL_BUBBLE,
                 mem_wb: CTRL_BUBBLE, pc_wen: 1'b0};
    end
  end

  assign ctrl_if_id  = CTRL_W'(w_ctrl.if_id);
  assign ctrl_id_ex  = CTRL_W'(w_ctrl.id_ex);
  assign ctrl_ex_mem = CTRL_W'(w_ctrl.ex_mem);
  assign ctrl_mem_wb = CTRL_W'(w_ctrl.mem_wb);
  assign pc_wen      = w_ctrl.pc_wen;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_wen) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
